i2c_target_byte_engine: RTL and testbench

I2C target (responder) byte engine: the bus-side counterpart of the team's I2C initiator byte path. It watches SCL/SDA, detects START/STOP, matches a 7-bit address, and ACKs. It receives write bytes to a host-side register, or shifts out host-supplied bytes on reads. SDA is open-drain, driven only via an output-enable pulling low; SCL is never driven (no clock stretching).

---
 rtl/i2c_target_byte_engine.sv | 222 ++++++++++++++++++++++
 tb/tb_i2c_target_byte_engine.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_byte_engine.sv
// I2C target byte engine: synchronizes SCL/SDA, detects START/STOP, matches a
// 7-bit address, ACKs, and moves bytes to/from the host. SDA is open-drain via Sda_oe.
module i2c_target_byte_engine #(
  parameter logic [6:0] ADDR        = 7'h42,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Scl_in,
  input  logic       Sda_in,
  output logic       Sda_oe,
  input  logic [7:0] Tx_data,
  output logic       Tx_req,
  output logic [7:0] Rx_data,
  output logic       Rx_valid,
  output logic       Addr_match,
  output logic       Busy
);

  localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_IGNORE,
    ST_ADDR_ACK,
    ST_RX,
    ST_RX_ACK,
    ST_TX,
    ST_TX_ACK
  } state_t;

  logic [STAGES-1:0] scl_sync_reg, sda_sync_reg;
  logic              scl_d_reg, sda_d_reg;
  logic              scl_s, sda_s;
  logic              scl_rise, scl_fall, sda_rise, sda_fall;
  logic              start_det, stop_det;

  state_t     state_reg, state_next;
  logic [2:0] cnt_reg, cnt_next;
  logic       done_reg, done_next;
  logic [7:0] shift_reg, shift_next;
  logic       rw_reg, rw_next;
  logic       oe_reg, oe_next;
  logic       busy_reg, busy_next;
  logic [7:0] rx_data_reg, rx_data_next;
  logic       rx_valid_reg, rx_valid_next;
  logic       tx_req_reg, tx_req_next;
  logic       addr_match_reg, addr_match_next;

  // Synchronizers and edge-detect copies reset to 1 so an idle bus looks idle.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      scl_sync_reg <= '1;
      sda_sync_reg <= '1;
      scl_d_reg    <= 1'b1;
      sda_d_reg    <= 1'b1;
    end else begin
      scl_sync_reg <= {scl_sync_reg[STAGES-2:0], Scl_in};
      sda_sync_reg <= {sda_sync_reg[STAGES-2:0], Sda_in};
      scl_d_reg    <= scl_sync_reg[STAGES-1];
      sda_d_reg    <= sda_sync_reg[STAGES-1];
    end
  end

  assign scl_s     = scl_sync_reg[STAGES-1];
  assign sda_s     = sda_sync_reg[STAGES-1];
  assign scl_rise  = scl_s & ~scl_d_reg;
  assign scl_fall  = ~scl_s & scl_d_reg;
  assign sda_rise  = sda_s & ~sda_d_reg;
  assign sda_fall  = ~sda_s & sda_d_reg;
  assign start_det = sda_fall & scl_s;
  assign stop_det  = sda_rise & scl_s;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_reg      <= ST_IDLE;
      cnt_reg        <= 3'd7;
      done_reg       <= 1'b0;
      shift_reg      <= 8'h00;
      rw_reg         <= 1'b0;
      oe_reg         <= 1'b0;
      busy_reg       <= 1'b0;
      rx_data_reg    <= 8'h00;
      rx_valid_reg   <= 1'b0;
      tx_req_reg     <= 1'b0;
      addr_match_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      done_reg       <= done_next;
      shift_reg      <= shift_next;
      rw_reg         <= rw_next;
      oe_reg         <= oe_next;
      busy_reg       <= busy_next;
      rx_data_reg    <= rx_data_next;
      rx_valid_reg   <= rx_valid_next;
      tx_req_reg     <= tx_req_next;
      addr_match_reg <= addr_match_next;
    end
  end

  // done_reg marks "8th rise seen" in ADDR/RX/TX, and "initiator ACKed" in TX_ACK.
  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    done_next       = done_reg;
    shift_next      = shift_reg;
    rw_next         = rw_reg;
    oe_next         = oe_reg;
    busy_next       = busy_reg;
    rx_data_next    = rx_data_reg;
    rx_valid_next   = 1'b0;
    tx_req_next     = 1'b0;
    addr_match_next = 1'b0;

    if (start_det) begin
      busy_next  = 1'b1;
      oe_next    = 1'b0;
      cnt_next   = 3'd7;
      done_next  = 1'b0;
      state_next = ST_ADDR;
    end else if (stop_det) begin
      busy_next  = 1'b0;
      oe_next    = 1'b0;
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE: begin
        end
        ST_ADDR, ST_RX: begin
          if (scl_rise && !done_reg) begin
            shift_next = {shift_reg[6:0], sda_s};
            if (cnt_reg == 3'd0) done_next = 1'b1;
            else                 cnt_next  = cnt_reg - 3'd1;
          end else if (scl_fall && done_reg) begin
            if (state_reg == ST_ADDR) begin
              if (shift_reg[7:1] == ADDR) begin
                oe_next         = 1'b1;
                addr_match_next = 1'b1;
                rw_next         = shift_reg[0];
                state_next      = ST_ADDR_ACK;
              end else begin
                state_next = ST_IGNORE;
              end
            end else begin
              rx_data_next  = shift_reg;
              rx_valid_next = 1'b1;
              oe_next       = 1'b1;
              state_next    = ST_RX_ACK;
            end
          end
        end
        ST_IGNORE: begin
          oe_next = 1'b0;
        end
        ST_ADDR_ACK: begin
          if (scl_rise && rw_reg) begin
            tx_req_next = 1'b1;
          end else if (scl_fall) begin
            cnt_next  = 3'd7;
            done_next = 1'b0;
            if (rw_reg) begin
              shift_next = Tx_data;
              oe_next    = ~Tx_data[7];
              state_next = ST_TX;
            end else begin
              oe_next    = 1'b0;
              state_next = ST_RX;
            end
          end
        end
        ST_RX_ACK: begin
          if (scl_fall) begin
            oe_next    = 1'b0;
            cnt_next   = 3'd7;
            done_next  = 1'b0;
            state_next = ST_RX;
          end
        end
        ST_TX: begin
          if (scl_rise && !done_reg) begin
            if (cnt_reg == 3'd0) done_next = 1'b1;
            else                 cnt_next  = cnt_reg - 3'd1;
          end else if (scl_fall && done_reg) begin
            oe_next    = 1'b0;
            done_next  = 1'b0;
            state_next = ST_TX_ACK;
          end else if (scl_fall) begin
            shift_next = {shift_reg[6:0], 1'b0};
            oe_next    = ~shift_reg[6];
          end
        end
        ST_TX_ACK: begin
          if (scl_rise) begin
            if (!sda_s) begin
              tx_req_next = 1'b1;
              done_next   = 1'b1;
            end else begin
              state_next = ST_IGNORE;
            end
          end else if (scl_fall && done_reg) begin
            shift_next = Tx_data;
            oe_next    = ~Tx_data[7];
            cnt_next   = 3'd7;
            done_next  = 1'b0;
            state_next = ST_TX;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  assign Sda_oe     = oe_reg;
  assign Busy       = busy_reg;
  assign Rx_data    = rx_data_reg;
  assign Rx_valid   = rx_valid_reg;
  assign Tx_req     = tx_req_reg;
  assign Addr_match = addr_match_reg;

endmodule

// File: tb/tb_i2c_target_byte_engine.sv
// Bench for i2c_target_byte_engine: an I2C initiator model drives the bus and a
// transaction-level model predicts SDA drive, pulses and received data.
module tb_i2c_target_byte_engine;
  localparam logic [6:0] OWN = 7'h42;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic       scl = 1'b1;
  logic       m_sda = 1'b1;
  logic [7:0] Tx_data = 8'h00;
  logic       Sda_oe, Tx_req, Rx_valid, Addr_match, Busy;
  logic [7:0] Rx_data;
  logic       sda_bus;

  assign sda_bus = m_sda & ~Sda_oe;

  always #5 Clk = ~Clk;

  i2c_target_byte_engine #(.ADDR(OWN), .SYNC_STAGES(2)) dut (
    .Clk(Clk), .Rst(Rst), .Scl_in(scl), .Sda_in(sda_bus), .Sda_oe(Sda_oe),
    .Tx_data(Tx_data), .Tx_req(Tx_req), .Rx_data(Rx_data), .Rx_valid(Rx_valid),
    .Addr_match(Addr_match), .Busy(Busy)
  );

  int checks = 0, failures = 0;
  int am_cnt = 0, tr_cnt = 0, rxv_cnt = 0, exp_am = 0, exp_tr = 0;
  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];
  logic [7:0] xb [0:3];
  logic [7:0] rd_got [0:3];
  logic [7:0] last_rx = 8'h00;
  logic check_en = 1'b0, exp_oe_v = 1'b0, exp_busy = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  // Compare process: SDA drive and Busy in stable windows, pulses every cycle.
  initial begin
    logic pv_rx, pv_am, pv_tr;
    pv_rx = 1'b0; pv_am = 1'b0; pv_tr = 1'b0;
    forever begin
      @(negedge Clk);
      if (check_en) begin
        chk("sda_oe", 32'(Sda_oe), 32'(exp_oe_v));
        chk("busy", 32'(Busy), 32'(exp_busy));
      end
      if (Rx_valid) begin
        rxv_cnt++;
        chk("rx_valid_width", 32'(pv_rx), 32'd0);
        chk("rx_valid_oe", 32'(Sda_oe), 32'd1);
        if (rx_q.size() == 0) chk("rx_valid_unexpected", 32'(Rx_valid), 32'd0);
        else chk("rx_data_at_valid", 32'(Rx_data), 32'(rx_q.pop_front()));
      end
      if (Addr_match) begin
        am_cnt++;
        chk("addr_match_width", 32'(pv_am), 32'd0);
        chk("addr_match_oe", 32'(Sda_oe), 32'd1);
      end
      if (Tx_req) begin
        tr_cnt++;
        chk("tx_req_width", 32'(pv_tr), 32'd0);
        if (tx_q.size() == 0) chk("tx_req_unexpected", 32'(Tx_req), 32'd0);
        else Tx_data = tx_q.pop_front();
      end
      pv_rx = Rx_valid; pv_am = Addr_match; pv_tr = Tx_req;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  // One SCL clock: data set mid-low, SDA drive checked mid-high.
  task automatic clock_bit(input logic m_bit, input logic exp_oe, output logic seen);
    wait_clk(4); m_sda = m_bit;
    wait_clk(4); scl = 1'b1;
    wait_clk(4); exp_oe_v = exp_oe; check_en = 1'b1;
    seen = sda_bus;
    wait_clk(3); check_en = 1'b0;
    wait_clk(1); scl = 1'b0;
  endtask

  task automatic do_start();
    if (scl == 1'b0) begin
      wait_clk(4); m_sda = 1'b1;
      wait_clk(4); scl = 1'b1;
    end
    wait_clk(4); m_sda = 1'b0; exp_busy = 1'b1;
    wait_clk(5); exp_oe_v = 1'b0; check_en = 1'b1;
    wait_clk(2); check_en = 1'b0;
    wait_clk(1); scl = 1'b0;
  endtask

  task automatic do_stop();
    wait_clk(4); m_sda = 1'b0;
    wait_clk(4); scl = 1'b1;
    wait_clk(4); m_sda = 1'b1; exp_busy = 1'b0;
    wait_clk(5); exp_oe_v = 1'b0; check_en = 1'b1;
    wait_clk(2); check_en = 1'b0;
    wait_clk(4);
  endtask

  task automatic send_addr(input logic [6:0] a, input logic rw, output logic m);
    logic [7:0] ab;
    logic seen;
    ab = {a, rw};
    m = (a == OWN);
    if (m) exp_am++;
    for (int i = 7; i >= 0; i--) clock_bit(ab[i], 1'b0, seen);
    clock_bit(1'b1, m, seen);
  endtask

  // Expected target behaviour per byte: silent unless addressed; ACK writes;
  // on reads drive ~bit and release for the initiator's ACK/NACK.
  task automatic do_body(input logic [6:0] a, input logic rw, input int n);
    logic m, seen;
    logic [7:0] got;
    got = 8'h00;
    if (a == OWN && rw) begin
      for (int k = 0; k < n; k++) tx_q.push_back(xb[k]);
      exp_tr += n;
    end
    send_addr(a, rw, m);
    for (int k = 0; k < n; k++) begin
      if (!rw) begin
        if (m) begin rx_q.push_back(xb[k]); last_rx = xb[k]; end
        for (int i = 7; i >= 0; i--) clock_bit(xb[k][i], 1'b0, seen);
        clock_bit(1'b1, m, seen);
      end else begin
        for (int i = 7; i >= 0; i--) begin
          clock_bit(1'b1, m ? ~xb[k][i] : 1'b0, seen);
          got[i] = seen;
        end
        rd_got[k] = got;
        if (m) chk("read_byte", 32'(got), 32'(xb[k]));
        clock_bit((k == n - 1) ? 1'b1 : 1'b0, 1'b0, seen);
      end
    end
  endtask

  task automatic end_checks();
    chk("addr_match_count", 32'(am_cnt), 32'(exp_am));
    chk("tx_req_count", 32'(tr_cnt), 32'(exp_tr));
    chk("rx_pending", 32'(rx_q.size()), 32'd0);
    chk("tx_pending", 32'(tx_q.size()), 32'd0);
    chk("rx_data_held", 32'(Rx_data), 32'(last_rx));
  endtask

  task automatic rand_body(input int t);
    logic [6:0] a;
    logic rw;
    int n;
    a  = ($urandom_range(0, 1) == 1) ? OWN : 7'($urandom_range(0, 127));
    rw = 1'($urandom_range(0, 1));
    n  = $urandom_range(1, 3);
    for (int k = 0; k < 4; k++) xb[k] = 8'($urandom_range(0, 255));
    $display("xfer %0d addr=%02h rw=%0d bytes=%0d b0=%02h", t, a, rw, n, xb[0]);
    do_body(a, rw, n);
  endtask

  initial begin
    int am0, tr0, rxv0;
    logic m, seen;
    logic [7:0] pat;

    Rst = 1'b1;
    wait_clk(3);
    chk("reset_sda_oe", 32'(Sda_oe), 32'd0);
    chk("reset_busy", 32'(Busy), 32'd0);
    chk("reset_rx_data", 32'(Rx_data), 32'h00);
    chk("reset_rx_valid", 32'(Rx_valid), 32'd0);
    chk("reset_addr_match", 32'(Addr_match), 32'd0);
    chk("reset_tx_req", 32'(Tx_req), 32'd0);
    Rst = 1'b0;
    wait_clk(10);

    // Write 0x42/W, 0xA5
    $display("xfer write addr=42 data=a5");
    am0 = am_cnt; xb[0] = 8'hA5;
    do_start(); do_body(OWN, 1'b0, 1); do_stop(); end_checks();
    chk("t1_rx_data", 32'(Rx_data), 32'hA5);
    chk("t1_addr_match", 32'(am_cnt - am0), 32'd1);

    // Wrong address 0x43
    $display("xfer write addr=43 data=11");
    am0 = am_cnt; rxv0 = rxv_cnt; xb[0] = 8'h11;
    do_start(); do_body(7'h43, 1'b0, 1); do_stop(); end_checks();
    chk("t2_rx_data", 32'(Rx_data), 32'hA5);
    chk("t2_addr_match", 32'(am_cnt - am0), 32'd0);
    chk("t2_rx_valid", 32'(rxv_cnt - rxv0), 32'd0);

    // Read two bytes, ACK then NACK
    $display("xfer read addr=42 data=3c,f0");
    tr0 = tr_cnt; xb[0] = 8'h3C; xb[1] = 8'hF0;
    do_start(); do_body(OWN, 1'b1, 2); do_stop(); end_checks();
    chk("t3_byte0", 32'(rd_got[0]), 32'h3C);
    chk("t3_byte1", 32'(rd_got[1]), 32'hF0);
    chk("t3_tx_req", 32'(tr_cnt - tr0), 32'd2);

    // Write 0x55, repeated START, read one byte
    $display("xfer write 55 then Sr read 99");
    am0 = am_cnt; xb[0] = 8'h55;
    do_start(); do_body(OWN, 1'b0, 1);
    xb[0] = 8'h99;
    do_start(); do_body(OWN, 1'b1, 1); do_stop(); end_checks();
    chk("t4_rx_data", 32'(Rx_data), 32'h55);
    chk("t4_addr_match", 32'(am_cnt - am0), 32'd2);
    chk("t4_read", 32'(rd_got[0]), 32'h99);

    // STOP after four data bits
    $display("xfer write aborted after 4 bits");
    rxv0 = rxv_cnt; pat = 8'hC3;
    do_start(); send_addr(OWN, 1'b0, m);
    for (int i = 7; i >= 4; i--) clock_bit(pat[i], 1'b0, seen);
    do_stop(); end_checks();
    chk("t5_rx_data", 32'(Rx_data), 32'h55);
    chk("t5_rx_valid", 32'(rxv_cnt - rxv0), 32'd0);

    // Reset while ACKing a write byte
    $display("xfer write 3a with reset during ack");
    pat = 8'h3A;
    do_start(); send_addr(OWN, 1'b0, m);
    rx_q.push_back(pat); last_rx = pat;
    for (int i = 7; i >= 0; i--) clock_bit(pat[i], 1'b0, seen);
    wait_clk(5);
    chk("t6_oe_before_reset", 32'(Sda_oe), 32'd1);
    Rst = 1'b1;
    wait_clk(1);
    Rst = 1'b0;
    chk("t6_oe_after_reset", 32'(Sda_oe), 32'd0);
    chk("t6_busy_after_reset", 32'(Busy), 32'd0);
    chk("t6_rx_data_after_reset", 32'(Rx_data), 32'h00);
    last_rx = 8'h00; exp_busy = 1'b0;
    wait_clk(2); scl = 1'b1;
    wait_clk(8); scl = 1'b0;
    do_stop(); end_checks();
    $display("xfer write addr=42 data=7e after reset");
    xb[0] = 8'h7E;
    do_start(); do_body(OWN, 1'b0, 1); do_stop(); end_checks();
    chk("t6_rx_data_next", 32'(Rx_data), 32'h7E);

    // Randomized transactions, some chained with repeated START
    for (int t = 0; t < 40; t++) begin
      do_start();
      rand_body(t);
      if ($urandom_range(0, 3) == 0) begin
        do_start();
        rand_body(t);
      end
      do_stop();
      end_checks();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
